// File: rtl/smbm_client.sv
// smbm_client -- command front-end for a sorted-metric buffer manager.
//
// Commands are buffered in a FIFO, issued one at a time to the manager,
// and each one yields exactly one response on the rsp_* handshake.
//   clk, rst            : clock; synchronous active-high reset
//   cmd_valid/cmd_ready : command handshake (cmd_ready = FIFO not full)
//   cmd_op              : 0=ADD 1=DELETE 2=READ-filtered 3=READ-all
//   cmd_id/cmd_metrics/cmd_mask/cmd_metric_sel : command payload
//   opcode_o, opcode_in_o, id_o, metric_val_o, in_o, metric_x_o : to manager
//   done_i, out_list_i  : from manager; entry k = {val[7:0], ptr[ID_W-1:0]}
//   rsp_valid/rsp_ready : response handshake
//   rsp_op/rsp_hit/rsp_val/rsp_ptr/rsp_err : response payload
// Optional build macro SMBM_CLIENT_TIMEOUT_EN: bound the wait for done_i to
// TIMEOUT_CYC cycles and report expiry through rsp_err. Without it the wait
// is unbounded and rsp_err is tied low.
module smbm_client #(
  parameter int ID_W        = 6,
  parameter int NUM_METRICS = 2,
  parameter int FIFO_DEPTH  = 4,
  parameter int TIMEOUT_CYC = 15,
  localparam int N_ENT = 2**ID_W,
  localparam int MET_W = 8*NUM_METRICS,
  localparam int SEL_W = (NUM_METRICS > 1) ? $clog2(NUM_METRICS) : 1,
  localparam int ENT_W = 8 + ID_W
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               cmd_valid,
  output logic               cmd_ready,
  input  logic [1:0]         cmd_op,
  input  logic [ID_W-1:0]    cmd_id,
  input  logic [MET_W-1:0]   cmd_metrics,
  input  logic [N_ENT-1:0]   cmd_mask,
  input  logic [SEL_W-1:0]   cmd_metric_sel,
  output logic [2:0]         opcode_o,
  output logic [2:0]         opcode_in_o,
  output logic [ID_W-1:0]    id_o,
  output logic [MET_W-1:0]   metric_val_o,
  output logic [N_ENT-1:0]   in_o,
  output logic [SEL_W-1:0]   metric_x_o,
  input  logic               done_i,
  input  logic [N_ENT*ENT_W-1:0] out_list_i,
  output logic               rsp_valid,
  input  logic               rsp_ready,
  output logic [1:0]         rsp_op,
  output logic               rsp_hit,
  output logic [7:0]         rsp_val,
  output logic [ID_W-1:0]    rsp_ptr,
  output logic               rsp_err
);

  localparam int AW    = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CMD_W = 2 + ID_W + MET_W + N_ENT + SEL_W;

  if (FIFO_DEPTH < 1 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
    $error("smbm_client: FIFO_DEPTH must be a power of 2");
  end
  if (TIMEOUT_CYC < 1) begin : g_bad_timeout
    $error("smbm_client: TIMEOUT_CYC must be at least 1");
  end

  typedef enum logic [1:0] {OP_ADD, OP_DEL, OP_RDF, OP_RDA} op_t;
  typedef enum logic [2:0] {IDLE, ISSUE, WAIT, CAPTURE, RESP} state_t;

  // ---------------- command FIFO ----------------
  logic [CMD_W-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic [AW:0]      count;
  logic             push, pop;
  state_t           state;

  function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
    return (p == AW'(FIFO_DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign cmd_ready = (count != (AW+1)'(FIFO_DEPTH));
  assign push      = cmd_valid && cmd_ready;
  assign pop       = (state == IDLE) && (count != '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= ptr_inc(wr_ptr);
      if (pop)  rd_ptr <= ptr_inc(rd_ptr);
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= {cmd_op, cmd_id, cmd_metrics, cmd_mask, cmd_metric_sel};
  end

  logic [1:0]       h_op_raw;
  op_t              h_op;
  logic [ID_W-1:0]  h_id;
  logic [MET_W-1:0] h_met;
  logic [N_ENT-1:0] h_mask;
  logic [SEL_W-1:0] h_sel;

  assign {h_op_raw, h_id, h_met, h_mask, h_sel} = mem[rd_ptr];
  assign h_op = op_t'(h_op_raw);

  // ---------------- first valid list entry ----------------
  // Entries equal to all-ones are empty slots; the lowest non-empty wins.
  logic            cap_hit;
  logic [7:0]      cap_val;
  logic [ID_W-1:0] cap_ptr;

  always_comb begin
    cap_hit = 1'b0;
    cap_val = '0;
    cap_ptr = '0;
    for (int unsigned k = 0; k < N_ENT; k++) begin
      if (!cap_hit && out_list_i[k*ENT_W +: ENT_W] != '1) begin
        cap_hit            = 1'b1;
        {cap_val, cap_ptr} = out_list_i[k*ENT_W +: ENT_W];
      end
    end
  end

  // ---------------- optional wait timeout ----------------
  logic wait_expired;
`ifdef SMBM_CLIENT_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);
  logic [CNT_W-1:0] tmo_cnt;
  logic             rsp_err_q;
  assign wait_expired = (tmo_cnt == CNT_W'(TIMEOUT_CYC - 1));
  assign rsp_err      = rsp_err_q;
`else
  assign wait_expired = 1'b0;
  assign rsp_err      = 1'b0;
`endif

  // ---------------- control FSM ----------------
  op_t c_op;

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      c_op         <= OP_ADD;
      opcode_o     <= 3'b111;
      opcode_in_o  <= '0;
      id_o         <= '0;
      metric_val_o <= '0;
      in_o         <= '0;
      metric_x_o   <= '0;
      rsp_valid    <= 1'b0;
      rsp_op       <= '0;
      rsp_hit      <= 1'b0;
      rsp_val      <= '0;
      rsp_ptr      <= '0;
`ifdef SMBM_CLIENT_TIMEOUT_EN
      tmo_cnt      <= '0;
      rsp_err_q    <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (pop) begin
            c_op         <= h_op;
            id_o         <= h_id;
            metric_val_o <= h_met;
            in_o         <= h_mask;
            metric_x_o   <= h_sel;
            case (h_op)
              OP_ADD:  opcode_o <= 3'b000;
              OP_DEL:  opcode_o <= 3'b001;
              default: opcode_o <= 3'b010;
            endcase
            case (h_op)
              OP_RDF:  opcode_in_o <= 3'b010;
              OP_RDA:  opcode_in_o <= 3'b101;
              default: opcode_in_o <= 3'b000;
            endcase
            state <= ISSUE;
          end
        end
        ISSUE: begin
          opcode_o <= 3'b111;
`ifdef SMBM_CLIENT_TIMEOUT_EN
          tmo_cnt  <= '0;
`endif
          state    <= WAIT;
        end
        WAIT: begin
          // done_i takes priority over a timeout expiring in the same cycle.
          if (done_i || wait_expired) begin
            opcode_in_o  <= '0;
            id_o         <= '0;
            metric_val_o <= '0;
            in_o         <= '0;
            metric_x_o   <= '0;
            if (done_i && (c_op == OP_RDF || c_op == OP_RDA)) begin
              state <= CAPTURE;
            end else begin
              rsp_valid <= 1'b1;
              rsp_op    <= c_op;
              rsp_hit   <= 1'b0;
              rsp_val   <= '0;
              rsp_ptr   <= '0;
`ifdef SMBM_CLIENT_TIMEOUT_EN
              rsp_err_q <= !done_i;
`endif
              state     <= RESP;
            end
          end
`ifdef SMBM_CLIENT_TIMEOUT_EN
          else begin
            tmo_cnt <= tmo_cnt + 1'b1;
          end
`endif
        end
        CAPTURE: begin
          rsp_valid <= 1'b1;
          rsp_op    <= c_op;
          rsp_hit   <= cap_hit;
          rsp_val   <= cap_val;
          rsp_ptr   <= cap_ptr;
`ifdef SMBM_CLIENT_TIMEOUT_EN
          rsp_err_q <= 1'b0;
`endif
          state     <= RESP;
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_smbm_client.sv
module tb_smbm_client;
  localparam int ID_W = 6;
  localparam int NM   = 2;
  localparam int FD   = 4;
  localparam int TO   = 15;
  localparam int NE   = 2**ID_W;
  localparam int EW   = 8 + ID_W;
  localparam int MW   = 8*NM;
  localparam int SW   = 1;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              cmd_valid = 1'b0;
  logic              cmd_ready;
  logic [1:0]        cmd_op = '0;
  logic [ID_W-1:0]   cmd_id = '0;
  logic [MW-1:0]     cmd_metrics = '0;
  logic [NE-1:0]     cmd_mask = '0;
  logic [SW-1:0]     cmd_metric_sel = '0;
  logic [2:0]        opcode_o, opcode_in_o;
  logic [ID_W-1:0]   id_o;
  logic [MW-1:0]     metric_val_o;
  logic [NE-1:0]     in_o;
  logic [SW-1:0]     metric_x_o;
  logic              done_i = 1'b0;
  logic [NE*EW-1:0]  out_list_i = '1;
  logic              rsp_valid;
  logic              rsp_ready = 1'b0;
  logic [1:0]        rsp_op;
  logic              rsp_hit;
  logic [7:0]        rsp_val;
  logic [ID_W-1:0]   rsp_ptr;
  logic              rsp_err;

  smbm_client #(.ID_W(ID_W), .NUM_METRICS(NM), .FIFO_DEPTH(FD), .TIMEOUT_CYC(TO)) dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_id(cmd_id), .cmd_metrics(cmd_metrics),
    .cmd_mask(cmd_mask), .cmd_metric_sel(cmd_metric_sel),
    .opcode_o(opcode_o), .opcode_in_o(opcode_in_o), .id_o(id_o),
    .metric_val_o(metric_val_o), .in_o(in_o), .metric_x_o(metric_x_o),
    .done_i(done_i), .out_list_i(out_list_i),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_op(rsp_op),
    .rsp_hit(rsp_hit), .rsp_val(rsp_val), .rsp_ptr(rsp_ptr), .rsp_err(rsp_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]       op;
    logic [ID_W-1:0]  id;
    logic [MW-1:0]    met;
    logic [NE-1:0]    mask;
    logic [SW-1:0]    sel;
    logic [NE*EW-1:0] list;
  } cmd_t;

  typedef struct {
    logic [1:0]      op;
    logic            hit;
    logic [7:0]      val;
    logic [ID_W-1:0] ptr;
    logic            err;
    bit              vp;   // val/ptr are meaningful (READ or error)
  } rsp_t;

  cmd_t iss_q[$];
  rsp_t rsp_q[$];

  int n_chk  = 0;
  int n_pass = 0;
  int cyc    = 0;
  int issue_cyc = 0;
  bit seen_issue = 0;
  int mgr_mode = 0;   // 0 normal, 1 never done, 2 done two cycles after issue
  int rdy_mode = 2;   // 0 random, 1 hold low, 2 hold high

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) $display("FAIL %s: actual=%0h required=%0h", nm, act, exp);
    else n_pass++;
  endtask

  // Reference: READ returns the lowest-index entry that is not all-ones.
  function automatic rsp_t ref_rsp(input cmd_t c, input logic err);
    rsp_t r;
    logic [EW-1:0] e;
    r.op = c.op; r.hit = 0; r.val = 0; r.ptr = 0; r.err = err;
    r.vp = c.op[1] || err;
    if (!err && c.op[1]) begin
      for (int k = 0; k < NE; k++) begin
        e = c.list[k*EW +: EW];
        if (!r.hit && e != {EW{1'b1}}) begin
          r.hit = 1;
          r.val = e[EW-1:ID_W];
          r.ptr = e[ID_W-1:0];
        end
      end
    end
    return r;
  endfunction

  function automatic cmd_t rand_cmd();
    cmd_t c;
    int first;
    c.op   = 2'($urandom_range(0, 3));
    c.id   = ID_W'($urandom);
    c.met  = MW'($urandom);
    c.mask = {$urandom, $urandom};
    c.sel  = SW'($urandom);
    c.list = '1;
    if ($urandom_range(0, 3) != 0) begin
      first = $urandom_range(0, NE-1);
      for (int k = first; k < NE; k++) c.list[k*EW +: EW] = EW'($urandom);
    end
    return c;
  endfunction

  task automatic send(input cmd_t c, input logic err);
    int w = 0;
    @(negedge clk);
    cmd_valid = 1; cmd_op = c.op; cmd_id = c.id; cmd_metrics = c.met;
    cmd_mask = c.mask; cmd_metric_sel = c.sel;
    while (!cmd_ready && w < 500) begin
      @(negedge clk);
      w++;
    end
    if (w >= 500) begin
      chk("cmd_accept_timeout", 1, 0);
      cmd_valid = 0;
    end else begin
      @(posedge clk);
      iss_q.push_back(c);
      rsp_q.push_back(ref_rsp(c, err));
    end
  endtask

  task automatic idle_cmd();
    @(negedge clk);
    cmd_valid = 0;
  endtask

  task automatic drain();
    int w = 0;
    while ((iss_q.size() != 0 || rsp_q.size() != 0) && w < 3000) begin
      @(posedge clk);
      w++;
    end
    if (w >= 3000) chk("drain_timeout", 1, 0);
    repeat (3) @(posedge clk);
  endtask

  task automatic check_reset_vals(input string p);
    chk({p, "_cmd_ready"}, 64'(cmd_ready), 1);
    chk({p, "_opcode_o"}, 64'(opcode_o), 7);
    chk({p, "_opcode_in_o"}, 64'(opcode_in_o), 0);
    chk({p, "_id_o"}, 64'(id_o), 0);
    chk({p, "_metric_val_o"}, 64'(metric_val_o), 0);
    chk({p, "_in_o"}, 64'(in_o), 0);
    chk({p, "_metric_x_o"}, 64'(metric_x_o), 0);
    chk({p, "_rsp_valid"}, 64'(rsp_valid), 0);
    chk({p, "_rsp_fields"}, 64'({rsp_op, rsp_hit, rsp_val, rsp_ptr, rsp_err}), 0);
  endtask

  // rsp_ready driver
  initial forever begin
    @(negedge clk);
    rsp_ready = (rdy_mode == 0) ? ($urandom_range(0, 2) != 0) : (rdy_mode == 2);
  end

  // Manager model: checks the issued request and answers with done_i.
  initial forever begin
    cmd_t c;
    int lat;
    logic [2:0] eopc;
    @(posedge clk); #1;
    if (!rst && opcode_o !== 3'b111) begin
      if (iss_q.size() == 0) begin
        chk("spurious_issue", 64'(opcode_o), 7);
      end else begin
        c = iss_q.pop_front();
        eopc = (c.op == 2'd0) ? 3'b000 : (c.op == 2'd1) ? 3'b001 : 3'b010;
        chk("opcode_o", 64'(opcode_o), 64'(eopc));
        chk("id_o", 64'(id_o), 64'(c.id));
        chk("metric_val_o", 64'(metric_val_o), 64'(c.met));
        chk("in_o", 64'(in_o), 64'(c.mask));
        chk("metric_x_o", 64'(metric_x_o), 64'(c.sel));
        if (c.op[1]) chk("opcode_in_o", 64'(opcode_in_o), (c.op == 2'd3) ? 64'd5 : 64'd2);
        out_list_i = c.list;
        issue_cyc  = cyc;
        seen_issue = 1;
        if (mgr_mode == 1) begin
          @(posedge clk); #1;
          chk("issue_one_cycle", 64'(opcode_o), 7);
        end else begin
          lat = (mgr_mode == 2) ? 2 : (c.op[1] ? $urandom_range(1, 4) : $urandom_range(2, 5));
          for (int i = 0; i < lat; i++) begin
            @(posedge clk); #1;
            if (i == 0) chk("issue_one_cycle", 64'(opcode_o), 7);
            if (mgr_mode == 0 || i == 0) begin
              chk("id_o_hold", 64'(id_o), 64'(c.id));
              chk("in_o_hold", 64'(in_o), 64'(c.mask));
            end
          end
          done_i = 1;
          @(posedge clk); #1;
          done_i = 0;
        end
      end
    end
  end

  // Response monitor: sampled after the falling edge, where valid/ready are
  // exactly the values the next rising edge will act on.
  initial begin
    bit pend = 0;
    logic [1:0] p_op; logic p_hit; logic [7:0] p_val; logic [ID_W-1:0] p_ptr; logic p_err;
    rsp_t e;
    forever begin
      @(negedge clk); #1;
      if (rst) begin
        pend = 0;
      end else if (rsp_valid) begin
        if (pend) chk("rsp_stable", 64'({rsp_op, rsp_hit, rsp_val, rsp_ptr, rsp_err}),
                      64'({p_op, p_hit, p_val, p_ptr, p_err}));
        if (rsp_ready) begin
          if (rsp_q.size() == 0) begin
            chk("unexpected_rsp", 64'(rsp_valid), 0);
          end else begin
            e = rsp_q.pop_front();
            chk("rsp_op", 64'(rsp_op), 64'(e.op));
            chk("rsp_hit", 64'(rsp_hit), 64'(e.hit));
            chk("rsp_err", 64'(rsp_err), 64'(e.err));
            if (e.vp) begin
              chk("rsp_val", 64'(rsp_val), 64'(e.val));
              chk("rsp_ptr", 64'(rsp_ptr), 64'(e.ptr));
            end
          end
          pend = 0;
        end else begin
          pend = 1;
          p_op = rsp_op; p_hit = rsp_hit; p_val = rsp_val; p_ptr = rsp_ptr; p_err = rsp_err;
        end
      end else begin
        if (pend) chk("rsp_valid_dropped", 64'(rsp_valid), 1);
        pend = 0;
      end
    end
  end

  initial begin
    cmd_t c;
    int w;
    repeat (2) @(posedge clk);
    #1;
    check_reset_vals("reset");
    rst = 0;

    // ADD id=5 metrics {20,7}
    c = rand_cmd();
    c.op = 2'd0; c.id = 6'd5; c.met = {8'd20, 8'd7}; c.sel = 0;
    send(c, 0);
    idle_cmd();
    drain();

    // READ-filtered: entry0 empty, entry1 = {20,5}
    c = rand_cmd();
    c.op = 2'd2; c.sel = 0; c.mask = 64'h20; c.list = '1;
    c.list[1*EW +: EW] = {8'd20, 6'd5};
    send(c, 0);
    // READ-all with every entry empty
    c = rand_cmd();
    c.op = 2'd3; c.list = '1;
    send(c, 0);
    idle_cmd();
    drain();

    // Back-to-back pushes with responses stalled: FIFO fills behind the one in flight
    rdy_mode = 1;
    for (int i = 0; i < 5; i++) begin
      c = rand_cmd();
      c.op = 2'd0;
      send(c, 0);
    end
    idle_cmd();
    repeat (10) @(negedge clk);
    chk("fifo_full_cmd_ready", 64'(cmd_ready), 0);
    rdy_mode = 0;
    drain();

    // Random traffic
    for (int i = 0; i < 60; i++) begin
      send(rand_cmd(), 0);
      if ($urandom_range(0, 2) == 0) begin
        idle_cmd();
        repeat ($urandom_range(0, 4)) @(negedge clk);
      end
    end
    idle_cmd();
    drain();

`ifdef SMBM_CLIENT_TIMEOUT_EN
    mgr_mode = 1;
    seen_issue = 0;
    c = rand_cmd();
    c.op = 2'd0;
    send(c, 1);
    idle_cmd();
    w = 0;
    while (!seen_issue && w < 100) begin
      @(posedge clk);
      w++;
    end
    w = 0;
    do begin
      @(posedge clk); #1;
      w++;
    end while (!rsp_valid && w < 100);
    chk("timeout_latency", 64'(cyc - issue_cyc), 64'(TO + 1));
    drain();
    mgr_mode = 0;
    send(rand_cmd(), 0);
    idle_cmd();
    drain();
`endif

    // Reset one cycle into WAIT, done arriving afterwards is ignored
    mgr_mode = 2;
    rdy_mode = 2;
    seen_issue = 0;
    c = rand_cmd();
    c.op = 2'd2;
    send(c, 0);
    idle_cmd();
    w = 0;
    while (!seen_issue && w < 100) begin
      @(posedge clk);
      w++;
    end
    if (!seen_issue) chk("rst_test_issue_timeout", 0, 1);
    @(posedge clk); #1;
    rst = 1;
    @(posedge clk); #1;
    rst = 0;
    void'(rsp_q.pop_back());
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      chk("post_rst_no_rsp", 64'(rsp_valid), 0);
      chk("post_rst_opcode", 64'(opcode_o), 7);
    end
    check_reset_vals("midop_reset");
    mgr_mode = 0;
    send(rand_cmd(), 0);
    idle_cmd();
    drain();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/smbm_client.md
SMBM_CLIENT -- requirements
Module: smbm_client

Interface
REQ-001 SHALL have parameter ID_W, default 6, meaning the id width; the manager holds 2**ID_W entries.
REQ-002 SHALL have parameter NUM_METRICS, default 2, meaning the metric count; metric values are 8 bits each.
REQ-003 SHALL have parameter FIFO_DEPTH, default 4, meaning the command FIFO depth; it SHALL be a power of 2.
REQ-004 SHALL have parameter TIMEOUT_CYC, default 15, meaning the maximum cycles to wait for done.
REQ-005 SHALL have clk, input, 1 bit: the clock; all logic rises on clk.
REQ-006 SHALL have rst, input, 1 bit: reset, synchronous, active-high.
REQ-007 SHALL have cmd_valid / cmd_ready, input / output, 1 bit each: the command handshake.
REQ-008 SHALL have cmd_op, input, 2 bits: 0=ADD, 1=DELETE, 2=READ-filtered, 3=READ-all.
REQ-009 SHALL have cmd_id, input, ID_W bits; cmd_metrics, input, 8*NUM_METRICS bits; cmd_mask, input, 2**ID_W bits; cmd_metric_sel, input, clog2(NUM_METRICS) bits.
REQ-010 SHALL have the manager-side outputs opcode_o (3 bits), opcode_in_o (3 bits), id_o, metric_val_o, in_o and metric_x_o.
REQ-011 SHALL have the manager-side inputs done_i (1 bit) and out_list_i (2**ID_W*(8+ID_W) bits); entry k is {val[7:0], ptr[ID_W-1:0]} at slice k.
REQ-012 SHALL have rsp_valid / rsp_ready, output / input: the response handshake.
REQ-013 SHALL have rsp_op (2 bits), rsp_hit (1 bit), rsp_val (8 bits), rsp_ptr (ID_W bits) and rsp_err (1 bit), all outputs.

Function
REQ-014 SHALL buffer commands in a FIFO; cmd_ready = !full; a push occurs on cmd_valid&&cmd_ready.
REQ-015 SHALL use FSM states IDLE, ISSUE, WAIT, CAPTURE, RESP.
REQ-016 IDLE: on FIFO non-empty -> ISSUE; the head is popped into a command register in the same cycle.
REQ-017 ISSUE: opcode_o = 000 for ADD, 001 for DELETE, 010 for either READ, for exactly one cycle; then -> WAIT.
REQ-018 Outside ISSUE, opcode_o SHALL be 3'b111, which the manager treats as idle.
REQ-019 id_o, metric_val_o, in_o, metric_x_o and opcode_in_o SHALL hold the command-register values from ISSUE until leaving WAIT.
REQ-020 opcode_in_o SHALL be 010 for READ-filtered and 101 for READ-all.
REQ-021 WAIT: on done_i=1, READ ops -> CAPTURE; other ops -> RESP with rsp_hit=0.
REQ-022 CAPTURE (one cycle after done) SHALL sample out_list_i and pick the lowest index k whose entry is not all-ones.
REQ-023 In CAPTURE, rsp_hit=1 with rsp_val/rsp_ptr = entry k; if no such entry, rsp_hit=0 and rsp_val/rsp_ptr = 0; then -> RESP.
REQ-024 RESP: rsp_valid=1 and the rsp_* outputs stable until rsp_ready; on the handshake -> IDLE.
REQ-025 Issue-to-done minimum latency SHALL be 2 cycles for ADD/DELETE and 1 cycle for READ; at most one command is outstanding.
REQ-026 A command push while in RESP with the FIFO full SHALL be refused (cmd_ready=0); no command is ever dropped or reordered.
REQ-027 Simultaneous push and pop with the FIFO full SHALL be allowed only as a pop; the count SHALL never exceed FIFO_DEPTH.
REQ-028 done_i seen in IDLE, ISSUE or RESP SHALL be ignored.

Reset
REQ-029 On rst, SHALL set: state=IDLE, FIFO empty, cmd_ready=1, opcode_o=111, opcode_in_o=0, id_o=0, metric_val_o=0, in_o=0, metric_x_o=0, rsp_*=0.
REQ-030 rst mid-operation SHALL abandon the in-flight command; a done_i arriving after reset SHALL be ignored.

Configuration
REQ-031 With SMBM_CLIENT_TIMEOUT_EN defined, a WAIT-state counter SHALL be active.
REQ-032 With the macro defined, if done_i is absent for TIMEOUT_CYC cycles in WAIT: -> RESP with rsp_err=1, rsp_hit=0.
REQ-033 Without the macro, WAIT SHALL be unbounded, rsp_err SHALL be tied 0, and no counter is present.

Verification
REQ-034 ADD id=5, metrics {20,7}; model done 2 cycles after opcode -> opcode_o=000 for 1 cycle; one response, op=0, hit=0, err=0.
REQ-035 READ-filtered, sel=0, mask=0x20; entry0=all-ones, entry1={val 20, ptr 5} -> rsp_hit=1, rsp_val=20, rsp_ptr=5, opcode_in_o=010.
REQ-036 READ-all with every entry all-ones -> rsp_hit=0, rsp_val=0, rsp_ptr=0, opcode_in_o=101.
REQ-037 Push 5 commands back-to-back with rsp_ready=0 -> cmd_ready drops after 4 are buffered; all 5 respond in order once rsp_ready=1.
REQ-038 TIMEOUT_EN build, done never asserted -> rsp_err=1 exactly 15 cycles after entering WAIT; the next command then issues normally.
REQ-039 rst asserted 1 cycle into WAIT, done pulsed the next cycle -> no response produced; all outputs at reset values.
